// File: rtl/imem_loader_if.sv
// Byte-stream / instruction-memory write bundle for imem_loader.
// master = byte source and memory side, slave = the loader itself.
interface imem_loader_if;
    logic        start;
    logic [5:0]  len;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output start, len, byte_in, byte_valid,
        input  byte_ready, wr_en, wr_addr, wr_data, busy, done, err
    );

    modport slave (
        input  start, len, byte_in, byte_valid,
        output byte_ready, wr_en, wr_addr, wr_data, busy, done, err
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: assembles big-endian words from a byte stream into instruction memory.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int DEPTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    imem_loader_if.slave bus
);

    localparam logic [29:0] DEPTH_W = 30'(DEPTH);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE} state_t;
`endif

    state_t      state_reg, state_next;
    logic [29:0] len_reg, len_next;
    logic [29:0] index_reg, index_next;
    logic [1:0]  bcnt_reg, bcnt_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] data_reg, data_next;
    logic [29:0] len_ext;
    logic [23:0] lanes;
    logic        ready;
    logic        xfer;

    assign len_ext = {24'd0, bus.len};

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign ready = (state_reg == RECV) || (state_reg == CHECK);
`else
    assign ready = (state_reg == RECV);
`endif
    assign xfer = bus.byte_valid && ready;

    // One holding register per leading byte; the fourth byte goes straight into the word.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            logic [7:0] lane_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lane_reg <= '0;
                end else if (state_reg == RECV && xfer && bcnt_reg == 2'(gi)) begin
                    lane_reg <= bus.byte_in;
                end
            end
            assign lanes[23-8*gi -: 8] = lane_reg;
        end
    endgenerate

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum_reg, csum_next;
    logic       err_reg, err_next;
`endif

    always_comb begin
        state_next = state_reg;
        len_next   = len_reg;
        index_next = index_reg;
        bcnt_next  = bcnt_reg;
        addr_next  = addr_reg;
        data_next  = data_reg;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_next  = csum_reg;
        err_next   = err_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    index_next = '0;
                    bcnt_next  = '0;
                    len_next   = (len_ext > DEPTH_W) ? DEPTH_W : len_ext;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_next  = '0;
                    err_next   = 1'b0;
`endif
                    state_next = (bus.len == 6'd0) ? DONE : RECV;
                end
            end
            RECV: begin
                if (xfer) begin
                    bcnt_next = bcnt_reg + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_next = csum_reg ^ bus.byte_in;
`endif
                    if (bcnt_reg == 2'd3) begin
                        data_next  = {lanes, bus.byte_in};
                        addr_next  = {index_reg, 2'b00};
                        state_next = WRITE;
                    end
                end
            end
            WRITE: begin
                index_next = index_reg + 30'd1;
                if ((index_reg + 30'd1) < len_reg) begin
                    state_next = RECV;
                end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_next = CHECK;
`else
                    state_next = DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                if (xfer) begin
                    if (bus.byte_in != csum_reg) begin
                        err_next = 1'b1;
                    end
                    state_next = DONE;
                end
            end
`endif
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Reset aborts a session in place: words already written stay, nothing is undone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            len_reg   <= '0;
            index_reg <= '0;
            bcnt_reg  <= '0;
            addr_reg  <= '0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            len_reg   <= len_next;
            index_reg <= index_next;
            bcnt_reg  <= bcnt_next;
            addr_reg  <= addr_next;
            data_reg  <= data_next;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_reg <= '0;
            err_reg  <= 1'b0;
        end else begin
            csum_reg <= csum_next;
            err_reg  <= err_next;
        end
    end
    assign bus.err  = err_reg;
    assign bus.busy = (state_reg == RECV) || (state_reg == WRITE) || (state_reg == CHECK);
`else
    assign bus.err  = 1'b0;
    assign bus.busy = (state_reg == RECV) || (state_reg == WRITE);
`endif

    assign bus.byte_ready = ready;
    assign bus.wr_en      = (state_reg == WRITE);
    assign bus.wr_addr    = addr_reg;
    assign bus.wr_data    = data_reg;
    assign bus.done       = (state_reg == DONE);

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 32, giving the instruction memory size in 32-bit words.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: a one-cycle request to begin a load session.
REQ-005 The block SHALL have port len, input, 6 bits: the number of words to load, sampled when start is accepted.
REQ-006 The block SHALL have port byte_in, input, 8 bits: the incoming program byte.
REQ-007 The block SHALL have port byte_valid, input, 1 bit: byte_in holds a valid byte.
REQ-008 The block SHALL have port byte_ready, output, 1 bit: the loader can accept a byte this cycle.
REQ-009 The block SHALL have port wr_en, output, 1 bit: the instruction memory write strobe.
REQ-010 The block SHALL have port wr_addr, output, 32 bits: the word-aligned byte address, so that the memory indexes wr_addr>>2.
REQ-011 The block SHALL have port wr_data, output, 32 bits: the assembled instruction word.
REQ-012 The block SHALL have port busy, output, 1 bit: a session is in progress, holding the CPU in stall.
REQ-013 The block SHALL have port done, output, 1 bit: a one-cycle pulse at the end of a session.
REQ-014 The block SHALL have port err, output, 1 bit: the sticky checksum-error flag.

Function
REQ-015 The FSM SHALL have states IDLE, RECV, WRITE, CHECK and DONE.
REQ-016 A byte SHALL transfer only on a cycle where byte_valid and byte_ready are both 1; byte_ready SHALL be 1 only in RECV and CHECK.
REQ-017 In IDLE, start=1 SHALL latch len, clear the word index and the byte count, and enter RECV; if len exceeds DEPTH the latched value SHALL be clamped to DEPTH.
REQ-018 start with len=0 SHALL go IDLE->DONE with no writes and no bytes accepted.
REQ-019 start SHALL be ignored while busy=1.
REQ-020 Words SHALL be assembled big-endian: the first byte goes to wr_data[31:24] and the fourth byte to wr_data[7:0].
REQ-021 The fourth byte transfer SHALL move RECV->WRITE.
REQ-022 In WRITE, for exactly one cycle, the block SHALL drive wr_en=1, wr_addr=index*4 and the full word.
REQ-023 After WRITE the index SHALL increment; the block SHALL return to RECV if words remain, else go to CHECK (macro defined) or DONE.
REQ-024 wr_en SHALL be 0 outside WRITE; wr_addr and wr_data SHALL hold their last values.
REQ-025 busy SHALL be 1 in RECV, WRITE and CHECK.
REQ-026 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-027 Gaps in byte_valid SHALL stall the FSM without losing partial-word state.

Reset
REQ-028 rst_n=0 SHALL force IDLE asynchronously, including mid-session, and clear every output, the index, the byte count and the checksum.
REQ-029 Words written before a mid-session reset SHALL remain in memory; the block SHALL NOT issue a rollback or any further write.

Configuration
REQ-030 With IMEM_LOADER_CHECKSUM_EN defined, the block SHALL keep a running XOR of all data bytes.
REQ-031 With IMEM_LOADER_CHECKSUM_EN defined, CHECK SHALL accept one extra byte; a mismatch against the running XOR SHALL set err, held until the next accepted start.
REQ-032 Without IMEM_LOADER_CHECKSUM_EN, the block SHALL have no CHECK state, accept no checksum byte, and tie err to 0.

Verification
REQ-033 len=3, bytes 20 08 00 14 / 20 09 00 0F / 01 28 80 2A streamed back-to-back -> writes 0x20080014@0, 0x2009000F@4, 0x0128802A@8; one done pulse; busy low afterwards.
REQ-034 byte_valid toggling 1/0 every cycle while loading len=1 word 0xDEADBEEF -> a single write of 0xDEADBEEF@0 after the fourth handshake.
REQ-035 len=40 -> exactly 32 writes, the last at wr_addr=0x7C; start pulsed mid-session is ignored.
REQ-036 rst_n low after 6 bytes of len=2 -> one write (word 0) only; all outputs 0; a next start loads from address 0.
REQ-037 With IMEM_LOADER_CHECKSUM_EN, len=1, bytes 01 02 03 04 and checksum byte 04 -> err=0; checksum byte 05 -> err=1 until the next start.
REQ-038 start with len=0 -> done pulse in the next cycle with no wr_en activity.
